// File: rtl/mem_wb_if.sv
// Bundle between the memory stage and the writeback stage. The master side
// carries the memory-stage result and the stall/flush controls, and the slave
// side is the writeback register stage. The wb_* signals go to the register
// file write port and to the forwarding unit.
interface mem_wb_if #(
  parameter int DATA_WIDTH = 32
);
  // memory-stage result and pipeline control
  logic                  me_valid;
  logic [DATA_WIDTH-1:0] me_pc;
  logic [DATA_WIDTH-1:0] me_addr;
  logic [DATA_WIDTH-1:0] me_rdata;
  logic [2:0]            me_control_mem_read;
  logic [4:0]            me_rd;
  logic                  me_reg_write;
  logic [1:0]            me_wb_sel;
  logic                  wb_stall;
  logic                  wb_flush;

  // registered writeback outputs
  logic                  wb_valid;
  logic [DATA_WIDTH-1:0] wb_pc;
  logic [4:0]            wb_rd;
  logic                  wb_reg_write;
  logic [DATA_WIDTH-1:0] wb_wdata;
  logic                  wb_misaligned;
  logic [63:0]           wb_instret;

  modport master (
    output me_valid, me_pc, me_addr, me_rdata, me_control_mem_read,
           me_rd, me_reg_write, me_wb_sel, wb_stall, wb_flush,
    input  wb_valid, wb_pc, wb_rd, wb_reg_write, wb_wdata,
           wb_misaligned, wb_instret
  );

  modport slave (
    input  me_valid, me_pc, me_addr, me_rdata, me_control_mem_read,
           me_rd, me_reg_write, me_wb_sel, wb_stall, wb_flush,
    output wb_valid, wb_pc, wb_rd, wb_reg_write, wb_wdata,
           wb_misaligned, wb_instret
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load formatting. It extracts bytes and
// halfwords from the DMEM word, sign- or zero-extends them, picks the
// register-file write value, flags misaligned loads and counts retired
// instructions. Every output comes straight from a flop, so no input reaches
// an output combinationally.
module mem_wb_stage #(
  parameter int DATA_WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  mem_wb_if.slave bus_io
);

  localparam logic [2:0] MR_LB  = 3'b001;
  localparam logic [2:0] MR_LH  = 3'b010;
  localparam logic [2:0] MR_LW  = 3'b011;
  localparam logic [2:0] MR_LBU = 3'b100;
  localparam logic [2:0] MR_LHU = 3'b101;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  // True for the five load encodings. Codes 110 and 111 count as "no load".
  function automatic logic is_load(input logic [2:0] kind);
    logic res;
    case (kind)
      MR_LB, MR_LH, MR_LW, MR_LBU, MR_LHU: res = 1'b1;
      default:                             res = 1'b0;
    endcase
    return res;
  endfunction

  // The access is not naturally aligned for its size. Byte loads are always aligned.
  function automatic logic is_misaligned(input logic [2:0] kind, input logic [1:0] off);
    logic res;
    case (kind)
      MR_LH, MR_LHU: res = off[0];
      MR_LW:         res = (off != 2'b00);
      default:       res = 1'b0;
    endcase
    return res;
  endfunction

  // Picks the byte or halfword addressed by off out of the word and extends it.
  function automatic logic [DATA_WIDTH-1:0] extract_load(input logic [2:0] kind,
                                                         input logic [1:0] off,
                                                         input logic [DATA_WIDTH-1:0] word);
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [DATA_WIDTH-1:0] res;
    byte_v = word[{off, 3'b000} +: 8];
    half_v = off[1] ? word[31:16] : word[15:0];
    case (kind)
      MR_LB:   res = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
      MR_LBU:  res = {{(DATA_WIDTH-8){1'b0}}, byte_v};
      MR_LH:   res = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
      MR_LHU:  res = {{(DATA_WIDTH-16){1'b0}}, half_v};
      MR_LW:   res = word;
      default: res = {DATA_WIDTH{1'b0}};
    endcase
    return res;
  endfunction

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [4:0]            rd_q, rd_d;
  logic                  rw_q, rw_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  mis_q, mis_d;
  logic [63:0]           instret_q, instret_d;

  logic                  mis_s;
  logic [DATA_WIDTH-1:0] load_data_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  qual_rw_s;
  logic                  retire_s;

  // Formats the memory-stage result into what writeback would capture this edge.
  always_comb begin
    mis_s       = 1'b0;
    load_data_s = {DATA_WIDTH{1'b0}};
    sel_data_s  = bus_io.me_addr;
    if (bus_io.me_valid && is_load(bus_io.me_control_mem_read)) begin
      mis_s = is_misaligned(bus_io.me_control_mem_read, bus_io.me_addr[1:0]);
    end else begin
      mis_s = 1'b0;
    end
    if (mis_s) begin
      load_data_s = {DATA_WIDTH{1'b0}};
    end else begin
      load_data_s = extract_load(bus_io.me_control_mem_read, bus_io.me_addr[1:0],
                                 bus_io.me_rdata);
    end
    case (bus_io.me_wb_sel)
      SEL_ALU:  sel_data_s = bus_io.me_addr;
      SEL_LOAD: sel_data_s = load_data_s;
      SEL_PC4:  sel_data_s = bus_io.me_pc + DATA_WIDTH'(4);
      default:  sel_data_s = bus_io.me_addr;
    endcase
    qual_rw_s = bus_io.me_valid & bus_io.me_reg_write & (bus_io.me_rd != 5'd0) & ~mis_s;
    retire_s  = bus_io.me_valid & ~mis_s;
  end

  // Next state. Flush beats stall, and stall beats a normal load. The counter only moves on a load.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rd_d      = rd_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    mis_d     = mis_q;
    instret_d = instret_q;
    if (bus_io.wb_flush) begin
      valid_d = 1'b0;
      pc_d    = {DATA_WIDTH{1'b0}};
      rd_d    = 5'd0;
      rw_d    = 1'b0;
      wdata_d = {DATA_WIDTH{1'b0}};
      mis_d   = 1'b0;
    end else if (bus_io.wb_stall) begin
      valid_d = valid_q;
    end else begin
      valid_d   = bus_io.me_valid;
      pc_d      = bus_io.me_pc;
      rd_d      = bus_io.me_rd;
      rw_d      = qual_rw_s;
      wdata_d   = sel_data_s;
      mis_d     = mis_s;
      instret_d = instret_q + (retire_s ? 64'd1 : 64'd0);
    end
  end

  // Writeback pipeline registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= {DATA_WIDTH{1'b0}};
      rd_q      <= 5'd0;
      rw_q      <= 1'b0;
      wdata_q   <= {DATA_WIDTH{1'b0}};
      mis_q     <= 1'b0;
      instret_q <= 64'd0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      mis_q     <= mis_d;
      instret_q <= instret_d;
    end
  end

  assign bus_io.wb_valid      = valid_q;
  assign bus_io.wb_pc         = pc_q;
  assign bus_io.wb_rd         = rd_q;
  assign bus_io.wb_reg_write  = rw_q;
  assign bus_io.wb_wdata      = wdata_q;
  assign bus_io.wb_misaligned = mis_q;
  assign bus_io.wb_instret    = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage. A reference model works out the
// expected writeback state from the load rules using plain arithmetic. The
// bench runs directed cases followed by randomized traffic.
module tb_mem_wb_stage;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mem_wb_if #(.DATA_WIDTH(32)) bus ();

  mem_wb_stage #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic        m_valid;
  logic [31:0] m_pc;
  logic [4:0]  m_rd;
  logic        m_rw;
  logic [31:0] m_wdata;
  logic        m_mis;
  logic [63:0] m_instret;

  function automatic logic [135:0] obs_vec();
    return {bus.wb_valid, bus.wb_pc, bus.wb_rd, bus.wb_reg_write, bus.wb_wdata,
            bus.wb_misaligned, bus.wb_instret};
  endfunction

  function automatic logic [135:0] exp_vec();
    return {m_valid, m_pc, m_rd, m_rw, m_wdata, m_mis, m_instret};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_pc = 32'd0; m_rd = 5'd0; m_rw = 1'b0;
    m_wdata = 32'd0; m_mis = 1'b0; m_instret = 64'd0;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] addr,
                       input logic [31:0] rdata, input logic [2:0] mr, input logic [4:0] rd,
                       input logic rw, input logic [1:0] sel);
    bus.me_valid = v; bus.me_pc = pc; bus.me_addr = addr; bus.me_rdata = rdata;
    bus.me_control_mem_read = mr; bus.me_rd = rd; bus.me_reg_write = rw; bus.me_wb_sel = sel;
  endtask

  // Works out the expected outcome of the coming edge from the current inputs,
  // waits for the edge, and then commits the model.
  task automatic step();
    int unsigned sz;
    bit          sgn;
    int unsigned a4, b;
    logic [63:0] lv;
    logic        mis;
    logic [31:0] wd;
    logic        nv, nrw;
    logic [31:0] npc;
    logic [4:0]  nrd;
    logic [63:0] ncnt;
    sz = 0; sgn = 1'b0;
    case (bus.me_control_mem_read)
      3'd1: begin sz = 1; sgn = 1'b1; end
      3'd2: begin sz = 2; sgn = 1'b1; end
      3'd3: begin sz = 4; sgn = 1'b0; end
      3'd4: begin sz = 1; sgn = 1'b0; end
      3'd5: begin sz = 2; sgn = 1'b0; end
      default: sz = 0;
    endcase
    a4  = bus.me_addr % 4;
    mis = bus.me_valid && (sz != 0) && ((a4 % sz) != 0);
    lv  = 64'd0;
    if (sz != 0 && !mis) begin
      b  = (a4 / sz) * sz;
      lv = (64'(bus.me_rdata) >> (8 * b)) & ((64'd1 << (8 * sz)) - 64'd1);
      if (sgn && lv >= (64'd1 << (8 * sz - 1))) lv = lv - (64'd1 << (8 * sz));
    end
    if (bus.me_wb_sel == 2'd1)      wd = lv[31:0];
    else if (bus.me_wb_sel == 2'd2) wd = bus.me_pc + 32'd4;
    else                            wd = bus.me_addr;
    nv   = bus.me_valid;
    npc  = bus.me_pc;
    nrd  = bus.me_rd;
    nrw  = bus.me_valid && bus.me_reg_write && (bus.me_rd != 5'd0) && !mis;
    ncnt = m_instret + ((bus.me_valid && !mis) ? 64'd1 : 64'd0);
    @(posedge clk);
    #1;
    if (bus.wb_flush) begin
      m_valid = 1'b0; m_pc = 32'd0; m_rd = 5'd0; m_rw = 1'b0; m_wdata = 32'd0; m_mis = 1'b0;
    end else if (!bus.wb_stall) begin
      m_valid = nv; m_pc = npc; m_rd = nrd; m_rw = nrw; m_wdata = wd; m_mis = mis;
      m_instret = ncnt;
    end
  endtask

  task automatic test_reset();
    bus.wb_stall = 1'b0; bus.wb_flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 2'd0);
    rst_n = 1'b0;
    model_reset();
    #12;
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_initial got=%h exp=%h", obs_vec(), exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    // build some nonzero state, then reset with no clock edge in between
    drive(1'b1, 32'h0000_2000, 32'h0000_5555, 32'd0, 3'd0, 5'd7, 1'b1, 2'd0);
    step();
    step();
    bus.wb_stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_async got=%h exp=%h", obs_vec(), exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.wb_stall = 1'b0;
    step();
    total++;
    if (obs_vec() !== exp_vec() || bus.wb_instret !== 64'd1) begin
      bad++; $display("FAIL reset_first_update got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  kinds [5] = '{3'd1, 3'd4, 3'd2, 3'd5, 3'd3};
    logic [31:0] addrs [5] = '{32'h100, 32'h101, 32'h102, 32'h100, 32'h100};
    logic [31:0] want  [5] = '{32'hFFFF_FFA5, 32'h0000_00F0, 32'hFFFF_8000,
                               32'h0000_F0A5, 32'h8000_F0A5};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h400 + 32'(i * 4), addrs[i], 32'h8000_F0A5, kinds[i], 5'd3, 1'b1, 2'd1);
      step();
      total++;
      if (bus.wb_wdata !== want[i] || obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL load_ext_%0d got=%h exp=%h vec=%h", i, bus.wb_wdata, want[i], exp_vec());
      end
    end
  endtask

  task automatic test_misaligned();
    logic [2:0]  kinds [2] = '{3'd3, 3'd2};
    logic [31:0] addrs [2] = '{32'h102, 32'h103};
    logic [63:0] cnt_before;
    for (int i = 0; i < 2; i++) begin
      cnt_before = m_instret;
      drive(1'b1, 32'h800, addrs[i], 32'h8000_F0A5, kinds[i], 5'd5, 1'b1, 2'd1);
      step();
      total++;
      if (bus.wb_misaligned !== 1'b1 || bus.wb_reg_write !== 1'b0 || bus.wb_wdata !== 32'd0 ||
          bus.wb_instret !== cnt_before || obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL misaligned_%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_wb_sel();
    logic [63:0] cnt_before;
    drive(1'b1, 32'hFFFF_FFFC, 32'h0000_0040, 32'd0, 3'd0, 5'd1, 1'b1, 2'd2);
    step();
    total++;
    if (bus.wb_wdata !== 32'h0000_0000 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL sel_pc4_wrap got=%h exp=%h", bus.wb_wdata, 32'h0);
    end
    drive(1'b1, 32'h0000_0010, 32'h0000_1234, 32'd0, 3'd0, 5'd2, 1'b1, 2'd0);
    step();
    total++;
    if (bus.wb_wdata !== 32'h0000_1234 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL sel_alu got=%h exp=%h", bus.wb_wdata, 32'h1234);
    end
    cnt_before = m_instret;
    drive(1'b1, 32'h0000_0014, 32'h0000_0099, 32'd0, 3'd0, 5'd0, 1'b1, 2'd0);
    step();
    total++;
    if (bus.wb_reg_write !== 1'b0 || bus.wb_instret !== cnt_before + 64'd1 ||
        obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL rd0_counted got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_stall_flush();
    logic [135:0] frozen;
    drive(1'b1, 32'h0000_0100, 32'h0000_00AA, 32'd0, 3'd0, 5'd9, 1'b1, 2'd0);
    step();
    frozen = exp_vec();
    bus.wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(i), 32'h300 + 32'(i), 32'h0, 3'd0, 5'(10 + i), 1'b1, 2'(i % 3));
      step();
      total++;
      if (obs_vec() !== frozen || obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL stall_hold_%0d got=%h exp=%h", i, obs_vec(), frozen);
      end
    end
    bus.wb_flush = 1'b1;
    step();
    total++;
    if (bus.wb_valid !== 1'b0 || bus.wb_wdata !== 32'd0 || bus.wb_rd !== 5'd0 ||
        bus.wb_instret !== frozen[63:0] || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL stall_flush_bubble got=%h exp=%h", obs_vec(), exp_vec());
    end
    bus.wb_stall = 1'b0; bus.wb_flush = 1'b0;
    drive(1'b1, 32'h0000_0500, 32'h0000_0777, 32'd0, 3'd0, 5'd4, 1'b1, 2'd0);
    step();
    total++;
    if (bus.wb_instret !== frozen[63:0] + 64'd1 || bus.wb_wdata !== 32'h777 ||
        obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL release_capture got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [2:0] mr;
    logic [1:0] sel;
    logic [2:0] nonld [3] = '{3'd0, 3'd6, 3'd7};
    for (int i = 0; i < 400; i++) begin
      sel = 2'($urandom_range(0, 3));
      if (sel == 2'd1) mr = 3'($urandom_range(1, 5));
      else             mr = nonld[$urandom_range(0, 2)];
      drive(($urandom_range(0, 9) < 8), $urandom, $urandom, $urandom, mr,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), sel);
      bus.wb_stall = ($urandom_range(0, 99) < 15);
      bus.wb_flush = ($urandom_range(0, 99) < 8);
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    bus.wb_stall = 1'b0; bus.wb_flush = 1'b0;
  endtask

  task automatic test_wrap();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 2'd0);
    step();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(1'b1, 32'h0000_0900, 32'h0000_0001, 32'd0, 3'd0, 5'd6, 1'b1, 2'd0);
    step();
    total++;
    if (bus.wb_instret !== 64'd0 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL counter_wrap got=%h exp=%h", bus.wb_instret, 64'd0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_ext();
    test_misaligned();
    test_wb_sel();
    test_stall_flush();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
